// File: rtl/conv_frame_packer.sv
// Pixel-stream to flattened-frame packer feeding the parallel convolution stage.
// Collects NPIX words channel-major into one wide buffer and holds it until the consumer takes it.
module conv_frame_packer #(
  parameter  int BITWIDTH    = 8,
  parameter  int DATAWIDTH   = 28,
  parameter  int DATAHEIGHT  = 28,
  parameter  int DATACHANNEL = 3,
  localparam int NPIX        = DATAWIDTH * DATAHEIGHT * DATACHANNEL,
  localparam int CW          = $clog2(NPIX)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BITWIDTH-1:0]      s_data,
  input  logic                     s_last,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [BITWIDTH*NPIX-1:0] frame_data,
  output logic [CW-1:0]            pix_cnt,
  output logic                     frame_err
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_pix_cnt;
  logic [CW-1:0]           w_pix_cnt_nxt;
  logic                    r_frame_err;
  logic                    w_frame_err_nxt;
  logic                    w_accept;
  logic                    w_last_slot;
  logic [BITWIDTH*NPIX-1:0] r_frame_data;

  always_comb begin
    w_accept        = s_valid && (r_state == FILL);
    w_last_slot     = (r_pix_cnt == CW'(NPIX - 1));
    w_state_nxt     = r_state;
    w_pix_cnt_nxt   = r_pix_cnt;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          // The frame always completes on the final slot; s_last only decides whether that is an error.
          if (w_last_slot) begin
            w_state_nxt     = FULL;
            w_pix_cnt_nxt   = '0;
            w_frame_err_nxt = !s_last;
          end else if (s_last) begin
            w_pix_cnt_nxt   = '0;
            w_frame_err_nxt = 1'b1;
          end else begin
            w_pix_cnt_nxt   = r_pix_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        if (frame_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_pix_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_cnt   <= w_pix_cnt_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Aborted frames leave stale words behind; the next full frame rewrites every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data <= '0;
    end else if (w_accept) begin
      r_frame_data[int'(r_pix_cnt) * BITWIDTH +: BITWIDTH] <= s_data;
    end
  end

  assign s_ready     = (r_state == FILL);
  assign frame_valid = (r_state == FULL);
  assign frame_data  = r_frame_data;
  assign pix_cnt     = r_pix_cnt;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_conv_frame_packer.sv
// Bench for conv_frame_packer: 4x4x2 frames, directed beats against a frame-level reference model.
module tb_conv_frame_packer;
  localparam int BW = 8;
  localparam int NPIX = 32;
  localparam int FW = BW * NPIX;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] frame_data;
  logic [4:0]    pix_cnt;
  logic          frame_err;

  int n_chk = 0;
  int n_pass = 0;

  conv_frame_packer #(.BITWIDTH(8), .DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .pix_cnt(pix_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a buffer holding the frame, a fill position and a "frame held" flag.
  logic [BW-1:0] m_word [NPIX];
  bit            m_full;
  int            m_pos;
  bit            m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 0; m_pos = 0; m_err = 0;
      for (int i = 0; i < NPIX; i++) m_word[i] = '0;
    end else begin
      m_err = 0;
      if (m_full) begin
        if (frame_ready) m_full = 0;
      end else if (s_valid) begin
        m_word[m_pos] = s_data;
        m_pos++;
        if (m_pos == NPIX) begin
          m_full = 1; m_pos = 0; m_err = !s_last;
        end else if (s_last) begin
          m_pos = 0; m_err = 1;
        end
      end
    end
  end

  logic [BW-1:0] delivered [$];

  always @(negedge clk) begin
    logic [FW-1:0] mv;
    for (int i = 0; i < NPIX; i++) mv[i*BW +: BW] = m_word[i];
    chk("s_ready", FW'(s_ready), FW'(!m_full));
    chk("frame_valid", FW'(frame_valid), FW'(m_full));
    chk("pix_cnt", FW'(pix_cnt), FW'(m_pos));
    chk("frame_err", FW'(frame_err), FW'(m_err));
    chk("frame_data", frame_data, mv);
    if (rst_n && frame_valid && frame_ready)
      for (int i = 0; i < NPIX; i++) delivered.push_back(frame_data[i*BW +: BW]);
  end

  task automatic send_beat(input logic [BW-1:0] d, input logic l);
    int t = 0;
    logic ok;
    s_valid = 1'b1; s_data = d; s_last = l;
    do begin
      ok = s_ready;
      @(posedge clk); #1;
      t++;
    end while (!ok && t < 1000);
    if (!ok) chk("beat_timeout", 1, 0);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input bit last_flag, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send_beat(BW'(base + i), (i == n - 1) && last_flag);
    end
  endtask

  task automatic chk_words(input string name, input int base);
    logic [FW-1:0] exp;
    for (int i = 0; i < NPIX; i++) exp[i*BW +: BW] = BW'(base + i);
    chk(name, frame_data, exp);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_valid"}, FW'(frame_valid), 0);
    chk({name, "_ready"}, FW'(s_ready), 1);
    chk({name, "_cnt"}, FW'(pix_cnt), 0);
    chk({name, "_err"}, FW'(frame_err), 0);
    chk({name, "_data"}, frame_data, '0);
  endtask

  initial begin
    logic [FW-1:0] snap;
    int base_n;
    bit same;

    #3;
    reset_checks("rst0");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back frame, consumer ready
    frame_ready = 1'b1;
    send_frame(0, NPIX, 1, 0);
    chk("t1_valid", FW'(frame_valid), 1);
    chk_words("t1_words", 0);
    chk("t1_err", FW'(frame_err), 0);
    @(posedge clk); #1;
    chk("t1_valid_drop", FW'(frame_valid), 0);

    // 2: consumer stalls for 10 cycles
    frame_ready = 1'b0;
    send_frame(200, NPIX, 1, 0);
    snap = frame_data;
    s_valid = 1'b1; s_data = 8'h07;
    repeat (10) begin
      chk("t2_ready_low", FW'(s_ready), 0);
      chk("t2_hold", frame_data, snap);
      @(posedge clk); #1;
    end
    frame_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_released", FW'(frame_valid), 0);
    chk("t2_cnt0", FW'(pix_cnt), 0);
    @(posedge clk); #1;
    chk("t2_first_accept", FW'(pix_cnt), 1);
    s_valid = 1'b0;
    send_frame(1, NPIX - 1, 1, 0);
    @(posedge clk); #1;

    // 3: random gaps over three frames, everything delivered once and in order
    base_n = delivered.size();
    send_frame(0, NPIX, 1, 1);
    send_frame(32, NPIX, 1, 1);
    send_frame(64, NPIX, 1, 1);
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_count", FW'(delivered.size() - base_n), 96);
    same = 1;
    for (int i = 0; i < 96; i++)
      if (base_n + i >= delivered.size() || delivered[base_n + i] !== BW'(i)) same = 0;
    chk("t3_order", FW'(same), 1);

    // 4: early s_last aborts the partial frame
    send_frame(50, 11, 1, 0);
    chk("t4_err", FW'(frame_err), 1);
    chk("t4_cnt", FW'(pix_cnt), 0);
    @(posedge clk); #1;
    chk("t4_err_clear", FW'(frame_err), 0);
    frame_ready = 1'b0;
    send_frame(100, NPIX, 1, 0);
    chk("t4_valid", FW'(frame_valid), 1);
    chk("t4_word0", FW'(frame_data[7:0]), 100);
    chk_words("t4_words", 100);
    frame_ready = 1'b1;
    @(posedge clk); #1;

    // 5: missing s_last
    frame_ready = 1'b0;
    send_frame(3, NPIX, 0, 0);
    chk("t5_valid", FW'(frame_valid), 1);
    chk("t5_err", FW'(frame_err), 1);
    @(posedge clk); #1;
    chk("t5_err_pulse", FW'(frame_err), 0);
    chk("t5_hold", FW'(frame_valid), 1);
    frame_ready = 1'b1;
    @(posedge clk); #1;

    // 6: reset mid-fill, then while holding a frame
    frame_ready = 1'b0;
    send_frame(0, 20, 0, 0);
    #2 rst_n = 1'b0;
    #1 reset_checks("rst_fill");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(40, NPIX, 1, 0);
    chk("t6_full", FW'(frame_valid), 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("rst_full");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(10, NPIX, 1, 0);
    chk("t6_valid", FW'(frame_valid), 1);
    chk_words("t6_words", 10);
    frame_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
